cavlc_bitstream_shifter: RTL and testbench



---
 rtl/cavlc_pkg.sv | 12 +
 rtl/cavlc_bitstream_shifter.sv | 88 ++++++++
 tb/tb_cavlc_bitstream_shifter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cavlc_pkg.sv
// Shared types and default geometry for the CAVLC bitstream front end.
package cavlc_pkg;

  localparam int CAVLC_IN_WIDTH  = 32;
  localparam int CAVLC_WIN_WIDTH = 16;
  localparam int CAVLC_BUF_WIDTH = 64;

  // Also produced by the coeff-token decoder as its NumShift output.
  typedef logic [4:0] cavlc_shift_t;
  typedef logic [6:0] cavlc_bitcnt_t;

endpackage

// File: rtl/cavlc_bitstream_shifter.sv
// Left-aligned bit buffer feeding the coeff-token decoder: loads packed
// big-endian words, presents a WIN_WIDTH lookahead window, consumes NumShift bits.
module cavlc_bitstream_shifter
  import cavlc_pkg::*;
#(
  parameter int IN_WIDTH  = CAVLC_IN_WIDTH,
  parameter int WIN_WIDTH = CAVLC_WIN_WIDTH,
  parameter int BUF_WIDTH = CAVLC_BUF_WIDTH
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [IN_WIDTH-1:0]  InData,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic                 Flush,
  input  logic                 Advance,
  input  logic [4:0]           NumShift,
  output logic [WIN_WIDTH-1:0] BitstreamShifted,
  output logic                 WindowValid,
  output logic [6:0]           BitCount,
  output logic [31:0]          BitsConsumed,
  output logic                 ShiftError
);

  localparam cavlc_shift_t  WIN_MAX  = cavlc_shift_t'(WIN_WIDTH);
  localparam cavlc_bitcnt_t WIN_CNT  = cavlc_bitcnt_t'(WIN_WIDTH);
  localparam cavlc_bitcnt_t IN_CNT   = cavlc_bitcnt_t'(IN_WIDTH);
  localparam cavlc_bitcnt_t LOAD_MAX = cavlc_bitcnt_t'(BUF_WIDTH - IN_WIDTH);

  // Place a word so its MSB lands directly below the pos bits already held.
  function automatic logic [BUF_WIDTH-1:0] insert_word(input logic [IN_WIDTH-1:0] w,
                                                       input cavlc_bitcnt_t pos);
    return {w, {(BUF_WIDTH-IN_WIDTH){1'b0}}} >> pos;
  endfunction

  logic [BUF_WIDTH-1:0] buf_q, buf_d;
  cavlc_bitcnt_t        cnt_q, cnt_d;
  logic [31:0]          cons_q, cons_d;
  logic                 err_q, err_d;
  logic                 consume, load;
  cavlc_bitcnt_t        s;

  assign InReady          = !Reset && !Flush && (cnt_q <= LOAD_MAX);
  assign WindowValid      = (cnt_q >= WIN_CNT);
  assign BitstreamShifted = buf_q[BUF_WIDTH-1 -: WIN_WIDTH];
  assign BitCount         = cnt_q;
  assign BitsConsumed     = cons_q;
  assign ShiftError       = err_q;

  always_comb begin
    consume = Advance && WindowValid && (NumShift <= WIN_MAX);
    load    = InValid && InReady;
    s       = consume ? {2'b00, NumShift} : '0;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    cons_d  = cons_q;
    err_d   = err_q;
    if (Flush) begin
      buf_d = '0;
      cnt_d = '0;
    end else begin
      if (Advance && !consume) err_d = 1'b1;
      buf_d  = buf_q << s;
      cnt_d  = cnt_q - s;
      cons_d = cons_q + 32'(s);
      // Insert position uses the post-consume count so load and consume can overlap.
      if (load) begin
        buf_d = buf_d | insert_word(InData, cnt_d);
        cnt_d = cnt_d + IN_CNT;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      buf_q  <= '0;
      cnt_q  <= '0;
      cons_q <= '0;
      err_q  <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      cnt_q  <= cnt_d;
      cons_q <= cons_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_cavlc_bitstream_shifter.sv
// Bench for cavlc_bitstream_shifter: bit-queue reference model, directed and random traffic.
module tb_cavlc_bitstream_shifter;

  logic        Clk = 1'b0;
  logic        Reset, InValid, Flush, Advance;
  logic [31:0] InData;
  logic [4:0]  NumShift;
  logic        InReady, WindowValid, ShiftError;
  logic [15:0] BitstreamShifted;
  logic [6:0]  BitCount;
  logic [31:0] BitsConsumed;

  cavlc_bitstream_shifter dut (
    .Clk(Clk), .Reset(Reset), .InData(InData), .InValid(InValid), .InReady(InReady),
    .Flush(Flush), .Advance(Advance), .NumShift(NumShift),
    .BitstreamShifted(BitstreamShifted), .WindowValid(WindowValid),
    .BitCount(BitCount), .BitsConsumed(BitsConsumed), .ShiftError(ShiftError)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: the buffered stream as a plain queue of bits, earliest first.
  bit          mq[$];
  logic [31:0] m_cons;
  logic        m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_win();
    logic [15:0] w = '0;
    for (int i = 0; i < 16; i++)
      if (i < mq.size()) w[15-i] = mq[i];
    return w;
  endfunction

  task automatic check_state();
    chk("window", BitstreamShifted, m_win());
    chk("wvalid", WindowValid, mq.size() >= 16);
    chk("count", BitCount, mq.size());
    chk("consumed", BitsConsumed, m_cons);
    chk("shift_err", ShiftError, m_err);
  endtask

  task automatic step(input logic rst, input logic fl, input logic adv, input logic [4:0] ns,
                      input logic iv, input logic [31:0] d);
    logic rdy;
    Reset = rst; Flush = fl; Advance = adv; NumShift = ns; InValid = iv; InData = d;
    #1;
    rdy = !rst && !fl && (mq.size() <= 32);
    chk("in_ready", InReady, rdy);
    if (rst) begin
      mq.delete(); m_cons = '0; m_err = 1'b0;
    end else if (fl) begin
      mq.delete();
    end else begin
      if (adv) begin
        if (mq.size() >= 16 && ns <= 16) begin
          repeat (int'(ns)) void'(mq.pop_front());
          m_cons = m_cons + 32'(ns);
        end else m_err = 1'b1;
      end
      if (iv && rdy)
        for (int i = 31; i >= 0; i--) mq.push_back(d[i]);
    end
    @(posedge Clk);
    #1;
    check_state();
  endtask

  initial begin
    m_cons = '0; m_err = 1'b0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 5'd4, 1, 32'hFFFF_FFFF);
    chk("rst_window", BitstreamShifted, 16'h0);
    chk("rst_count", BitCount, 7'd0);
    chk("rst_err", ShiftError, 1'b0);

    step(0, 0, 0, 0, 1, 32'hA5F0_1234);
    chk("load1_win", BitstreamShifted, 16'hA5F0);
    chk("load1_cnt", BitCount, 7'd32);
    chk("load1_wv", WindowValid, 1'b1);
    step(0, 0, 1, 5'd4, 0, 0);
    chk("adv4_win", BitstreamShifted, 16'h5F01);
    chk("adv4_cnt", BitCount, 7'd28);
    chk("adv4_cons", BitsConsumed, 32'd4);
    step(0, 0, 1, 5'd16, 1, 32'hDEAD_BEEF);
    chk("both_cnt", BitCount, 7'd44);
    chk("both_win", BitstreamShifted, 16'h234D);
    chk("both_cons", BitsConsumed, 32'd20);

    // Fill to capacity, hold InValid while full, then drain two windows.
    step(0, 0, 1, 5'd12, 0, 0);
    step(0, 0, 0, 0, 1, 32'h0123_4567);
    chk("full_cnt", BitCount, 7'd64);
    step(0, 0, 0, 0, 1, 32'h89AB_CDEF);
    chk("full_hold", BitCount, 7'd64);
    step(0, 0, 1, 5'd16, 1, 32'h89AB_CDEF);
    step(0, 0, 1, 5'd16, 0, 0);
    chk("drain_cnt", BitCount, 7'd32);
    chk("drain_rdy", InReady, 1'b1);

    for (int n = 0; n < 1000; n++) begin
      logic [4:0] ns;
      ns = 5'($urandom_range(0, 16));
      step(0, 0, (mq.size() >= 16) && ($urandom_range(0, 3) != 0), ns,
           1'($urandom_range(0, 1)), $urandom);
    end
    chk("rand_no_err", ShiftError, 1'b0);

    // Illegal advances: short buffer, then oversize NumShift.
    step(0, 1, 1, 5'd4, 0, 0);
    step(0, 0, 0, 0, 1, 32'hCAFE_F00D);
    step(0, 0, 1, 5'd16, 0, 0);
    step(0, 0, 1, 5'd8, 0, 0);
    chk("short_cnt", BitCount, 7'd8);
    step(0, 0, 1, 5'd4, 0, 0);
    chk("short_err", ShiftError, 1'b1);
    chk("short_keep", BitCount, 7'd8);
    step(0, 0, 0, 0, 1, 32'h1357_9BDF);
    step(0, 0, 1, 5'd17, 0, 0);
    chk("big_keep", BitCount, 7'd40);
    step(0, 0, 1, 5'd3, 0, 0);
    chk("err_sticky", ShiftError, 1'b1);

    // Flush with data offered.
    step(0, 0, 1, 5'd0, 0, 0);
    step(0, 1, 1, 5'd5, 1, 32'h2468_ACE0);
    chk("flush_cnt", BitCount, 7'd0);
    chk("flush_wv", WindowValid, 1'b0);
    step(0, 0, 0, 0, 1, 32'h1111_2222);
    step(0, 0, 1, 5'd16, 1, 32'h3333_4444);
    step(1, 0, 1, 5'd4, 1, 32'h5555_6666);
    chk("mid_rst_cons", BitsConsumed, 32'd0);
    chk("mid_rst_err", ShiftError, 1'b0);
    chk("mid_rst_win", BitstreamShifted, 16'h0);
    step(0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
